// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin arbiter serialising two requesters onto a dual-port RAM
module ram_access_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_wr_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read,
  output logic [ADDR_WIDTH-1:0] ram_rd_address,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RDATA} state_t;
  state_t state, next_state;
  logic owner, last_grant, pick_b, done;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  // owner/last_grant: 0 = A, 1 = B; B wins alone or when both ask and A was served last
  assign pick_b = req_b & (~req_a | ~last_grant);
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && (req_a | req_b)) begin
        owner      <= pick_b;
        last_grant <= pick_b;
        cap_addr   <= pick_b ? addr_b : addr_a;
        cap_wdata  <= pick_b ? wdata_b : wdata_a;
      end
    end
  end
  always_comb begin
    next_state = state == READ ? RDATA :
                 state != IDLE ? IDLE :
                 !(req_a | req_b) ? IDLE :
                 (pick_b ? we_b : we_a) ? WRITE : READ;
  end
  always_comb begin
    ram_write      = state == WRITE;
    ram_read       = state == READ;
    ram_wr_address = ram_write ? cap_addr : '0;
    ram_data_in    = ram_write ? cap_wdata : '0;
    ram_rd_address = ram_read ? cap_addr : '0;
    done           = ram_write | (state == RDATA);
    ack_a          = done & ~owner;
    ack_b          = done & owner;
    rdata          = state == RDATA ? ram_data_out : '0;
    busy           = state != IDLE;
  end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: scoreboard bench for the two-requester RAM arbiter
module tb_ram_access_arbiter;
  localparam int DW = 64;
  localparam int AW = 12;
  typedef struct {
    logic          b;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic ack_a, ack_b, busy, ram_write, ram_read;
  logic [DW-1:0] rdata, ram_data_in, ram_data_out;
  logic [AW-1:0] ram_wr_address, ram_rd_address;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] shadow [logic [AW-1:0]];
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  wire [156:0] all_out = {ack_a, ack_b, rdata, busy, ram_write, ram_wr_address,
                          ram_data_in, ram_read, ram_rd_address};

  ram_access_arbiter dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata), .busy(busy),
    .ram_write(ram_write), .ram_wr_address(ram_wr_address), .ram_data_in(ram_data_in),
    .ram_read(ram_read), .ram_rd_address(ram_rd_address), .ram_data_out(ram_data_out)
  );

  always #5 clock = ~clock;

  // registered-read RAM behind the arbiter
  always @(posedge clock) begin
    if (ram_write) mem[ram_wr_address] <= ram_data_in;
    if (ram_read) ram_data_out <= mem[ram_rd_address];
  end

  task automatic push(input logic b, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.b = b;
    e.rd = rd;
    e.addr = a;
    e.data = rd ? shadow[a] : d;
    if (!rd) shadow[a] = d;
    sb.push_back(e);
  endtask

  task automatic set_a(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_a = r; we_a = w; addr_a = a; wdata_a = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_b = r; we_b = w; addr_b = a; wdata_b = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    repeat (2) @(negedge clock);
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (all_out !== '0) begin
        failures++;
        $display("FAIL idle_outputs cycle=%0d got=%h exp=0", i, all_out);
      end
    end
  endtask

  task automatic test_write_a;
    exp_t e;
    push(0, 0, 12'h005, 64'hDEAD_BEEF);
    set_a(1, 1, 12'h005, 64'hDEAD_BEEF);
    @(negedge clock);
    e = sb.pop_front();
    checks++;
    if ({ram_write, ack_a, ack_b, busy, ram_read} !== 5'b11010) begin
      failures++;
      $display("FAIL write_a_ctrl got=%b exp=11010", {ram_write, ack_a, ack_b, busy, ram_read});
    end
    checks++;
    if (ram_wr_address !== e.addr || ram_data_in !== e.data) begin
      failures++;
      $display("FAIL write_a_data got=%h/%h exp=%h/%h", ram_wr_address, ram_data_in, e.addr, e.data);
    end
    req_a = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || ack_a !== 1'b0) begin
      failures++;
      $display("FAIL write_a_done busy=%b ack_a=%b exp=0/0", busy, ack_a);
    end
  endtask

  task automatic test_read_a;
    exp_t e;
    push(0, 1, 12'h005, '0);
    set_a(1, 0, 12'h005, '0);
    @(negedge clock);
    checks++;
    if ({ram_read, ram_write, ack_a, ack_b} !== 4'b1000 || ram_rd_address !== 12'h005) begin
      failures++;
      $display("FAIL read_a_issue got=%b addr=%h exp=1000 addr=005", {ram_read, ram_write, ack_a, ack_b}, ram_rd_address);
    end
    @(negedge clock);
    e = sb.pop_front();
    checks++;
    if ({ack_a, ack_b, ram_read} !== 3'b100) begin
      failures++;
      $display("FAIL read_a_ack got=%b exp=100", {ack_a, ack_b, ram_read});
    end
    checks++;
    if (rdata !== e.data) begin
      failures++;
      $display("FAIL read_a_rdata got=%h exp=%h", rdata, e.data);
    end
    req_a = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_contention;
    exp_t e;
    int na = 1, nb = 1, done = 0, cycles = 0;
    logic pend_a = 1'b0, pend_b = 1'b0;
    sb.delete();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    push(0, 0, 12'h010, 64'h11);
    push(1, 0, 12'h020, 64'h22);
    set_a(1, 1, 12'h010, 64'h11);
    set_b(1, 1, 12'h020, 64'h22);
    @(negedge clock);
    e = sb.pop_front();
    checks++;
    if ({ack_a, ack_b, ram_write} !== 3'b101 || ram_wr_address !== e.addr || ram_data_in !== e.data) begin
      failures++;
      $display("FAIL contend_first got=%b %h/%h exp=101 %h/%h", {ack_a, ack_b, ram_write}, ram_wr_address, ram_data_in, e.addr, e.data);
    end
    req_a = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL contend_gap busy=%b exp=0", busy);
    end
    @(negedge clock);
    e = sb.pop_front();
    checks++;
    if ({ack_a, ack_b, ram_write} !== 3'b011 || ram_wr_address !== e.addr || ram_data_in !== e.data) begin
      failures++;
      $display("FAIL contend_second got=%b %h/%h exp=011 %h/%h", {ack_a, ack_b, ram_write}, ram_wr_address, ram_data_in, e.addr, e.data);
    end
    req_b = 1'b0;
    @(negedge clock);
    // both re-request and keep re-requesting after each ack: grants must alternate A, B, ...
    sb.delete();
    push(0, 0, 12'h100, 64'hA0);
    push(1, 0, 12'h200, 64'hB0);
    set_a(1, 1, 12'h100, 64'hA0);
    set_b(1, 1, 12'h200, 64'hB0);
    while (done < 6 && cycles < 60) begin
      @(negedge clock);
      cycles++;
      if (pend_a) begin
        pend_a = 1'b0;
        if (na < 3) begin
          push(0, 0, 12'h100 + 12'(na), 64'hA0 + 64'(na));
          set_a(1, 1, 12'h100 + 12'(na), 64'hA0 + 64'(na));
          na++;
        end
      end
      if (pend_b) begin
        pend_b = 1'b0;
        if (nb < 3) begin
          push(1, 0, 12'h200 + 12'(nb), 64'hB0 + 64'(nb));
          set_b(1, 1, 12'h200 + 12'(nb), 64'hB0 + 64'(nb));
          nb++;
        end
      end
      if (ack_a || ack_b) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL alternate_extra_ack ack_a=%b ack_b=%b exp=none", ack_a, ack_b);
        end else begin
          e = sb.pop_front();
          if (ack_a !== !e.b || ack_b !== e.b || ram_wr_address !== e.addr || ram_data_in !== e.data) begin
            failures++;
            $display("FAIL alternate_grant n=%0d got=%b%b %h/%h exp_b=%b %h/%h", done, ack_a, ack_b, ram_wr_address, ram_data_in, e.b, e.addr, e.data);
          end
        end
        if (ack_a) begin req_a = 1'b0; pend_a = 1'b1; end
        else begin req_b = 1'b0; pend_b = 1'b1; end
        done++;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    checks++;
    if (done != 6) begin
      failures++;
      $display("FAIL alternate_timeout acks=%0d exp=6", done);
    end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_mixed;
    exp_t e;
    sb.delete();
    push(0, 0, 12'h030, 64'h33);
    set_a(1, 1, 12'h030, 64'h33);
    @(negedge clock);
    e = sb.pop_front();
    checks++;
    if (ack_a !== 1'b1 || ram_wr_address !== e.addr) begin
      failures++;
      $display("FAIL mixed_setup ack_a=%b addr=%h exp=1 %h", ack_a, ram_wr_address, e.addr);
    end
    req_a = 1'b0;
    @(negedge clock);
    push(1, 0, 12'hFFF, 64'h1);
    push(0, 1, 12'h020, '0);
    set_b(1, 1, 12'hFFF, 64'h1);
    set_a(1, 0, 12'h020, '0);
    @(negedge clock);
    e = sb.pop_front();
    checks++;
    if ({ack_a, ack_b, ram_write, ram_read} !== 4'b0110 || ram_wr_address !== e.addr || ram_data_in !== e.data) begin
      failures++;
      $display("FAIL mixed_b_write got=%b %h/%h exp=0110 %h/%h", {ack_a, ack_b, ram_write, ram_read}, ram_wr_address, ram_data_in, e.addr, e.data);
    end
    req_b = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({ram_read, ram_write, ack_a} !== 3'b100 || ram_rd_address !== 12'h020) begin
      failures++;
      $display("FAIL mixed_a_issue got=%b addr=%h exp=100 addr=020", {ram_read, ram_write, ack_a}, ram_rd_address);
    end
    @(negedge clock);
    e = sb.pop_front();
    checks++;
    if ({ack_a, ack_b} !== 2'b10 || rdata !== e.data) begin
      failures++;
      $display("FAIL mixed_a_rdata got=%b %h exp=10 %h", {ack_a, ack_b}, rdata, e.data);
    end
    req_a = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_read;
    exp_t e;
    sb.delete();
    set_a(1, 0, 12'h005, '0);
    @(negedge clock);
    checks++;
    if (ram_read !== 1'b1) begin
      failures++;
      $display("FAIL midread_issue ram_read=%b exp=1", ram_read);
    end
    reset = 1'b1;
    req_a = 1'b0;
    @(negedge clock);
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL midread_reset got=%h exp=0", all_out);
    end
    reset = 1'b0;
    push(0, 0, 12'h040, 64'h44);
    push(1, 0, 12'h050, 64'h55);
    set_a(1, 1, 12'h040, 64'h44);
    set_b(1, 1, 12'h050, 64'h55);
    @(negedge clock);
    e = sb.pop_front();
    checks++;
    if ({ack_a, ack_b} !== 2'b10 || ram_wr_address !== e.addr || ram_data_in !== e.data) begin
      failures++;
      $display("FAIL midread_regrant got=%b %h/%h exp=10 %h/%h", {ack_a, ack_b}, ram_wr_address, ram_data_in, e.addr, e.data);
    end
    req_a = 1'b0;
    repeat (2) @(negedge clock);
    e = sb.pop_front();
    checks++;
    if ({ack_a, ack_b} !== 2'b01 || ram_wr_address !== e.addr) begin
      failures++;
      $display("FAIL midread_second got=%b %h exp=01 %h", {ack_a, ack_b}, ram_wr_address, e.addr);
    end
    req_b = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int n = 0, bad = 0;
    sb.delete();
    for (int i = 0; i < 5; i++) push(0, 0, 12'h060, 64'h66);
    set_a(1, 1, 12'h060, 64'h66);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (ack_b || (ram_write && ram_read)) bad++;
      if (ack_a) begin
        n++;
        if (sb.size() == 0) bad++;
        else begin
          e = sb.pop_front();
          if (ram_wr_address !== e.addr || ram_data_in !== e.data) bad++;
        end
      end
    end
    req_a = 1'b0;
    checks++;
    if (n != 5 || bad != 0) begin
      failures++;
      $display("FAIL b2b_writes acks=%0d errs=%0d exp=5/0", n, bad);
    end
    n = 0;
    bad = 0;
    sb.delete();
    for (int i = 0; i < 3; i++) push(0, 1, 12'h060, '0);
    set_a(1, 0, 12'h060, '0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      if (ack_b || (ram_write && ram_read)) bad++;
      if (ack_a) begin
        n++;
        if (sb.size() == 0) bad++;
        else begin
          e = sb.pop_front();
          if (rdata !== e.data) bad++;
        end
      end
    end
    req_a = 1'b0;
    checks++;
    if (n != 3 || bad != 0) begin
      failures++;
      $display("FAIL b2b_reads acks=%0d errs=%0d exp=3/0", n, bad);
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_a();
    test_read_a();
    test_contention();
    test_mixed();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
